// File: rtl/display_frame_buf_sched_if.sv
// ---------------------------------------------------------------------------
// display_frame_buf_sched_if
//
// Purpose: groups the writer handshake, the display DMA read-command channel,
// the frame-start/enable controls and the statistics outputs of the
// display frame-buffer scheduler into a single bundle.
//
// Signals (direction seen from the scheduler, modport "slave"):
//   enable        in   level, allows read commands to be issued
//   frame_start   in   one-cycle display VS pulse (already in sys_clk domain)
//   wr_req        in   writer buffer request, held until wr_grant
//   wr_grant      out  one-cycle grant pulse
//   wr_buf_idx    out  granted buffer index
//   wr_done       in   one-cycle pulse, granted buffer fully written
//   rd_cmd_valid  out  read command valid
//   rd_cmd_ready  in   read command accepted
//   rd_cmd_addr   out  start address of the buffer to read
//   rd_cmd_len    out  frame length in bytes
//   rd_done       in   one-cycle pulse, DMA finished reading the frame
//   rd_buf_idx    out  index of the buffer currently being read
//   sched_state   out  0 IDLE, 1 CMD, 2 BUSY
//   underrun_cnt, repeat_cnt, drop_cnt  out  saturating statistics
//
// The "master" modport is the mirror image, used by whatever drives the
// scheduler (writer DMA / display DMA / test environment).
// ---------------------------------------------------------------------------
interface display_frame_buf_sched_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  enable;
  logic                  frame_start;
  logic                  wr_req;
  logic                  wr_grant;
  logic [1:0]            wr_buf_idx;
  logic                  wr_done;
  logic                  rd_cmd_valid;
  logic                  rd_cmd_ready;
  logic [ADDR_WIDTH-1:0] rd_cmd_addr;
  logic [23:0]           rd_cmd_len;
  logic                  rd_done;
  logic [1:0]            rd_buf_idx;
  logic [1:0]            sched_state;
  logic [15:0]           underrun_cnt;
  logic [15:0]           repeat_cnt;
  logic [15:0]           drop_cnt;

  modport slave (
    input  enable,
    input  frame_start,
    input  wr_req,
    input  wr_done,
    input  rd_cmd_ready,
    input  rd_done,
    output wr_grant,
    output wr_buf_idx,
    output rd_cmd_valid,
    output rd_cmd_addr,
    output rd_cmd_len,
    output rd_buf_idx,
    output sched_state,
    output underrun_cnt,
    output repeat_cnt,
    output drop_cnt
  );

  modport master (
    output enable,
    output frame_start,
    output wr_req,
    output wr_done,
    output rd_cmd_ready,
    output rd_done,
    input  wr_grant,
    input  wr_buf_idx,
    input  rd_cmd_valid,
    input  rd_cmd_addr,
    input  rd_cmd_len,
    input  rd_buf_idx,
    input  sched_state,
    input  underrun_cnt,
    input  repeat_cnt,
    input  drop_cnt
  );
endinterface

// File: rtl/display_frame_buf_sched.sv
// ---------------------------------------------------------------------------
// display_frame_buf_sched
//
// Purpose: triple/quad frame-buffer scheduler for the HDMI display path.
// Hands DDR frame buffers to the frame writer, tracks the state of every
// buffer (FREE / WRITING / READY / READING) and issues one read command per
// display frame to the display DMA channel.
//
// Ports:
//   sys_clk  in  the only clock
//   rstn     in  asynchronous active-low reset
//   bus      display_frame_buf_sched_if.slave -- writer handshake, read
//            command channel, enable/frame_start and statistics counters
//
// Parameters:
//   NUM_BUF      buffer count, 3 or 4
//   ADDR_WIDTH   DMA address width
//   BASE_ADDR    address of buffer 0
//   FRAME_BYTES  bytes per frame; buffer k lives at BASE_ADDR + k*FRAME_BYTES
//
// Build option:
//   DISPLAY_FRAME_BUF_SCHED_STATS_EN  when defined, underrun_cnt, repeat_cnt
//   and drop_cnt are live saturating counters; otherwise they read 0 and no
//   counter logic exists. Scheduling is identical in both builds.
// ---------------------------------------------------------------------------
module display_frame_buf_sched #(
  parameter int                    NUM_BUF     = 3,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0100_0000,
  parameter logic [23:0]           FRAME_BYTES = 24'd1843200
) (
  input  logic                            sys_clk,
  input  logic                            rstn,
  display_frame_buf_sched_if.slave        bus
);

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_READING = 2'd3
  } buf_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_BUSY = 2'd2
  } sched_state_t;

  // Per-buffer start addresses, fixed at elaboration (wraps modulo 2^ADDR_WIDTH)
  logic [ADDR_WIDTH-1:0] buf_addr_tbl [NUM_BUF];

  generate
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_addr
      localparam logic [63:0] BUF_ADDR_FULL = 64'(BASE_ADDR) + 64'(gi) * 64'(FRAME_BYTES);
      assign buf_addr_tbl[gi] = BUF_ADDR_FULL[ADDR_WIDTH-1:0];
    end
  endgenerate

  buf_state_t            buf_state_reg  [NUM_BUF];
  buf_state_t            buf_state_mid  [NUM_BUF];  // after the write-side update
  buf_state_t            buf_state_next [NUM_BUF];  // after the read-side update

  sched_state_t          state_reg, state_next;
  logic                  wr_grant_reg;
  logic [1:0]            wr_buf_idx_reg;
  logic                  rd_cmd_valid_reg, rd_cmd_valid_next;
  logic [ADDR_WIDTH-1:0] rd_cmd_addr_reg, rd_cmd_addr_next;
  logic [1:0]            rd_buf_idx_reg, rd_buf_idx_next;

  // Buffer occupancy summary of the current (registered) states
  logic       writing_found, ready_found, reading_found, free_found;
  logic [1:0] writing_idx, ready_idx, reading_idx, free_idx;

  logic       grant_now;
  logic       wr_done_eff;
  logic       sel_ready_found;
  logic [1:0] sel_ready_idx;
  logic [1:0] pick_idx;

  logic       drop_event, repeat_event, underrun_event;

  // -------------------------------------------------------------------------
  // Occupancy scan. At most one buffer is WRITING/READY/READING at a time,
  // so only the FREE search needs a priority (lowest index wins).
  // -------------------------------------------------------------------------
  always_comb begin
    writing_found = 1'b0;
    writing_idx   = 2'd0;
    ready_found   = 1'b0;
    ready_idx     = 2'd0;
    reading_found = 1'b0;
    reading_idx   = 2'd0;
    free_found    = 1'b0;
    free_idx      = 2'd0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (buf_state_reg[i] == BUF_WRITING) begin
        writing_found = 1'b1;
        writing_idx   = 2'(i);
      end
      if (buf_state_reg[i] == BUF_READY) begin
        ready_found = 1'b1;
        ready_idx   = 2'(i);
      end
      if (buf_state_reg[i] == BUF_READING) begin
        reading_found = 1'b1;
        reading_idx   = 2'(i);
      end
      if (buf_state_reg[i] == BUF_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = 2'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Write side. A grant needs no WRITING buffer in the current state, so a
  // wr_done in the same cycle as wr_req can only lead to a later grant.
  // The wr_grant_reg term keeps the grant a single-cycle pulse.
  // -------------------------------------------------------------------------
  assign grant_now   = bus.wr_req && !writing_found && free_found && !wr_grant_reg;
  assign wr_done_eff = bus.wr_done && writing_found;
  assign drop_event  = wr_done_eff && ready_found;

  // A buffer finishing this cycle is already selectable by the reader.
  assign sel_ready_found = wr_done_eff || ready_found;
  assign sel_ready_idx   = wr_done_eff ? writing_idx : ready_idx;

  always_comb begin
    for (int i = 0; i < NUM_BUF; i++) begin
      buf_state_mid[i] = buf_state_reg[i];
      if (grant_now && free_idx == 2'(i)) begin
        buf_state_mid[i] = BUF_WRITING;
      end else if (wr_done_eff) begin
        if (buf_state_reg[i] == BUF_WRITING) begin
          buf_state_mid[i] = BUF_READY;
        end else if (buf_state_reg[i] == BUF_READY) begin
          buf_state_mid[i] = BUF_FREE;  // superseded frame is dropped
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read FSM: next state, registered-output next values, buffer hand-over.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    rd_cmd_valid_next = rd_cmd_valid_reg;
    rd_cmd_addr_next  = rd_cmd_addr_reg;
    rd_buf_idx_next   = rd_buf_idx_reg;
    pick_idx          = 2'd0;
    repeat_event      = 1'b0;
    underrun_event    = 1'b0;
    for (int i = 0; i < NUM_BUF; i++) begin
      buf_state_next[i] = buf_state_mid[i];
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.frame_start && bus.enable && (sel_ready_found || reading_found)) begin
          state_next        = ST_CMD;
          rd_cmd_valid_next = 1'b1;
          if (sel_ready_found) begin
            pick_idx = sel_ready_idx;
            // Newest frame takes over; the previously displayed one is released.
            for (int i = 0; i < NUM_BUF; i++) begin
              if (sel_ready_idx == 2'(i)) begin
                buf_state_next[i] = BUF_READING;
              end else if (buf_state_mid[i] == BUF_READING) begin
                buf_state_next[i] = BUF_FREE;
              end
            end
          end else begin
            // Nothing new: show the same frame again.
            pick_idx     = reading_idx;
            repeat_event = 1'b1;
          end
          rd_buf_idx_next = pick_idx;
          for (int i = 0; i < NUM_BUF; i++) begin
            if (pick_idx == 2'(i)) begin
              rd_cmd_addr_next = buf_addr_tbl[i];
            end
          end
        end
      end
      ST_CMD: begin
        underrun_event = bus.frame_start;
        if (bus.rd_cmd_ready) begin
          state_next        = ST_BUSY;
          rd_cmd_valid_next = 1'b0;
        end
      end
      ST_BUSY: begin
        underrun_event = bus.frame_start;
        if (bus.rd_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next        = ST_IDLE;
        rd_cmd_valid_next = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf_state
      always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
          buf_state_reg[gi] <= BUF_FREE;
        end else begin
          buf_state_reg[gi] <= buf_state_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_reg        <= ST_IDLE;
      wr_grant_reg     <= 1'b0;
      wr_buf_idx_reg   <= 2'd0;
      rd_cmd_valid_reg <= 1'b0;
      rd_cmd_addr_reg  <= '0;
      rd_buf_idx_reg   <= 2'd0;
    end else begin
      state_reg        <= state_next;
      wr_grant_reg     <= grant_now;
      if (grant_now) begin
        wr_buf_idx_reg <= free_idx;
      end
      rd_cmd_valid_reg <= rd_cmd_valid_next;
      rd_cmd_addr_reg  <= rd_cmd_addr_next;
      rd_buf_idx_reg   <= rd_buf_idx_next;
    end
  end

  // -------------------------------------------------------------------------
  // Statistics
  // -------------------------------------------------------------------------
`ifdef DISPLAY_FRAME_BUF_SCHED_STATS_EN
  logic [15:0] underrun_cnt_reg, repeat_cnt_reg, drop_cnt_reg;

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      underrun_cnt_reg <= 16'h0;
      repeat_cnt_reg   <= 16'h0;
      drop_cnt_reg     <= 16'h0;
    end else begin
      if (underrun_event && underrun_cnt_reg != 16'hFFFF) begin
        underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
      end
      if (repeat_event && repeat_cnt_reg != 16'hFFFF) begin
        repeat_cnt_reg <= repeat_cnt_reg + 16'd1;
      end
      if (drop_event && drop_cnt_reg != 16'hFFFF) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
    end
  end

  assign bus.underrun_cnt = underrun_cnt_reg;
  assign bus.repeat_cnt   = repeat_cnt_reg;
  assign bus.drop_cnt     = drop_cnt_reg;
`else
  // Event strobes are still produced by the scheduler but have no consumer.
  logic unused_stat_events;
  assign unused_stat_events = ^{underrun_event, repeat_event, drop_event};

  assign bus.underrun_cnt = 16'h0;
  assign bus.repeat_cnt   = 16'h0;
  assign bus.drop_cnt     = 16'h0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.wr_grant     = wr_grant_reg;
  assign bus.wr_buf_idx   = wr_buf_idx_reg;
  assign bus.rd_cmd_valid = rd_cmd_valid_reg;
  assign bus.rd_cmd_addr  = rd_cmd_addr_reg;
  assign bus.rd_cmd_len   = FRAME_BYTES;
  assign bus.rd_buf_idx   = rd_buf_idx_reg;
  assign bus.sched_state  = state_reg;

endmodule

// File: tb/tb_display_frame_buf_sched.sv
// ---------------------------------------------------------------------------
// tb_display_frame_buf_sched
//
// Self-checking bench for display_frame_buf_sched (3 buffers, default
// addresses). A directed vector table walks the main scenarios cycle by
// cycle, a few hand-written sequences cover stall, enable drop and
// asynchronous reset, and a random phase compares every output each cycle
// against a buffer-state reference model. Expected counter values follow
// DISPLAY_FRAME_BUF_SCHED_STATS_EN (zero when the macro is undefined).
// ---------------------------------------------------------------------------
module tb_display_frame_buf_sched;

  localparam int          NUM_BUF     = 3;
  localparam logic [31:0] BASE_ADDR   = 32'h0100_0000;
  localparam logic [23:0] FRAME_BYTES = 24'd1843200;
  localparam logic [31:0] ADDR_B0     = 32'h0100_0000;
  localparam logic [31:0] ADDR_B2     = 32'h0138_4000;

`ifdef DISPLAY_FRAME_BUF_SCHED_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic rstn    = 1'b0;
  always #5 sys_clk = ~sys_clk;

  display_frame_buf_sched_if #(.ADDR_WIDTH(32)) bus ();

  display_frame_buf_sched #(
    .NUM_BUF     (NUM_BUF),
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (BASE_ADDR),
    .FRAME_BYTES (FRAME_BYTES)
  ) dut (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ------------------------- reference model ------------------------------
  // Buffer states: 0 free, 1 writing, 2 ready, 3 reading. Mode: 0 idle,
  // 1 command pending, 2 DMA busy.
  int          mb [NUM_BUF];
  int          m_mode, m_widx, m_ridx, m_drop, m_rep, m_und;
  bit          m_grant, m_valid;
  logic [31:0] m_addr;

  function automatic void model_reset();
    for (int i = 0; i < NUM_BUF; i++) mb[i] = 0;
    m_mode = 0; m_widx = 0; m_ridx = 0; m_drop = 0; m_rep = 0; m_und = 0;
    m_grant = 1'b0; m_valid = 1'b0; m_addr = 32'h0;
  endfunction

  function automatic int first_in(input int st);
    for (int i = 0; i < NUM_BUF; i++) if (mb[i] == st) return i;
    return -1;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  function automatic void model_step(input bit en, fs, req, done, rdy, rdone);
    int w, r, rd, f;
    bit give;
    w  = first_in(1);
    r  = first_in(2);
    rd = first_in(3);
    f  = first_in(0);
    give = req && (w < 0) && (f >= 0) && !m_grant;
    if (done && w >= 0) begin
      if (r >= 0) begin
        mb[r]  = 0;
        m_drop = sat_inc(m_drop);
      end
      mb[w] = 2;
      r = w;
    end
    if (give) begin
      mb[f]  = 1;
      m_widx = f;
    end
    m_grant = give;
    if (m_mode == 0) begin
      if (fs && en && (r >= 0 || rd >= 0)) begin
        if (r >= 0) begin
          if (rd >= 0) mb[rd] = 0;
          mb[r]  = 3;
          m_ridx = r;
        end else begin
          m_ridx = rd;
          m_rep  = sat_inc(m_rep);
        end
        m_addr  = BASE_ADDR + 32'(m_ridx) * 32'(FRAME_BYTES);
        m_valid = 1'b1;
        m_mode  = 1;
      end
    end else if (m_mode == 1) begin
      if (fs) m_und = sat_inc(m_und);
      if (rdy) begin
        m_mode  = 2;
        m_valid = 1'b0;
      end
    end else begin
      if (fs) m_und = sat_inc(m_und);
      if (rdone) m_mode = 0;
    end
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
    return STATS_EN ? 32'(v) : 32'h0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, " wr_grant"},     32'(bus.wr_grant),     32'(m_grant));
    check({tag, " wr_buf_idx"},   32'(bus.wr_buf_idx),   32'(m_widx));
    check({tag, " rd_cmd_valid"}, 32'(bus.rd_cmd_valid), 32'(m_valid));
    check({tag, " rd_cmd_addr"},  bus.rd_cmd_addr,       m_addr);
    check({tag, " rd_cmd_len"},   32'(bus.rd_cmd_len),   32'(FRAME_BYTES));
    check({tag, " rd_buf_idx"},   32'(bus.rd_buf_idx),   32'(m_ridx));
    check({tag, " sched_state"},  32'(bus.sched_state),  32'(m_mode));
    check({tag, " drop_cnt"},     32'(bus.drop_cnt),     exp_cnt(m_drop));
    check({tag, " repeat_cnt"},   32'(bus.repeat_cnt),   exp_cnt(m_rep));
    check({tag, " underrun_cnt"}, 32'(bus.underrun_cnt), exp_cnt(m_und));
  endtask

  // ------------------------- stimulus helpers -----------------------------
  task automatic drive(input bit en, fs, req, done, rdy, rdone);
    @(negedge sys_clk);
    bus.enable       = en;
    bus.frame_start  = fs;
    bus.wr_req       = req;
    bus.wr_done      = done;
    bus.rd_cmd_ready = rdy;
    bus.rd_done      = rdone;
    @(posedge sys_clk);
    model_step(en, fs, req, done, rdy, rdone);
    #1;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rstn = 1'b0;
    bus.enable = 1'b0; bus.frame_start = 1'b0; bus.wr_req = 1'b0;
    bus.wr_done = 1'b0; bus.rd_cmd_ready = 1'b0; bus.rd_done = 1'b0;
    model_reset();
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
  endtask

  // ------------------------- directed table -------------------------------
  typedef struct {
    bit en, fs, req, done, rdy, rdone;
    bit          grant;
    int          widx;
    bit          valid;
    logic [31:0] addr;
    int          ridx, st, drop, rep, und;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit en, fs, req, done, rdy, rdone,
                              input bit g, input int wi, input bit va,
                              input logic [31:0] ad, input int ri, st, d, r, u);
    vec_t v;
    v.en = en; v.fs = fs; v.req = req; v.done = done; v.rdy = rdy; v.rdone = rdone;
    v.grant = g; v.widx = wi; v.valid = va; v.addr = ad; v.ridx = ri;
    v.st = st; v.drop = d; v.rep = r; v.und = u;
    return v;
  endfunction

  initial begin
    vec_t v;
    string tag;
    bus.enable = 1'b0; bus.frame_start = 1'b0; bus.wr_req = 1'b0;
    bus.wr_done = 1'b0; bus.rd_cmd_ready = 1'b0; bus.rd_done = 1'b0;
    model_reset();

    //             en fs rq dn rdy rdn | g  wi va addr     ri st d  r  u
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0)); // reset state
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0)); // nothing written: no cmd
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 0, 32'h0,   0, 0, 0, 0, 0)); // grant buf0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 0, 0, 32'h0,   0, 0, 0, 0, 0)); // buf0 ready
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 0, 1, ADDR_B0, 0, 1, 0, 0, 0)); // read buf0
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0, 0, ADDR_B0, 0, 2, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, ADDR_B0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, ADDR_B0, 0, 0, 0, 0, 0)); // grant buf1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 1, 0, ADDR_B0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 1, 0, ADDR_B0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 2, 0, ADDR_B0, 0, 0, 0, 0, 0)); // grant buf2
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 2, 0, ADDR_B0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 2, 0, ADDR_B0, 0, 0, 1, 0, 0)); // buf1 dropped
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 2, 1, ADDR_B2, 2, 1, 1, 0, 0)); // read buf2
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 2, 1, ADDR_B2, 2, 1, 1, 0, 1)); // underrun in CMD
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 2, 0, ADDR_B2, 2, 2, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 2, 0, ADDR_B2, 2, 2, 1, 0, 2)); // underrun in BUSY
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 2, 0, ADDR_B2, 2, 0, 1, 0, 2));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0,  0, 2, 1, ADDR_B2, 2, 1, 1, 1, 2)); // repeat buf2
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 2, 0, ADDR_B2, 2, 2, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 2, 0, ADDR_B2, 2, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 0, 0, ADDR_B2, 2, 0, 1, 1, 2)); // grant buf0
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, ADDR_B2, 2, 0, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0,  0, 0, 1, ADDR_B0, 0, 1, 1, 1, 2)); // done+fs same cycle
    vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 0, 0, ADDR_B0, 0, 2, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 0, 0, ADDR_B0, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 1, 0, ADDR_B0, 0, 0, 1, 1, 2)); // grant buf1
    vecs.push_back(mk(1, 0, 1, 1, 0, 0,  0, 1, 0, ADDR_B0, 0, 0, 1, 1, 2)); // done+req: no grant yet
    vecs.push_back(mk(1, 0, 1, 0, 0, 0,  1, 2, 0, ADDR_B0, 0, 0, 1, 1, 2)); // grant buf2
    vecs.push_back(mk(1, 0, 0, 1, 0, 0,  0, 2, 0, ADDR_B0, 0, 0, 2, 1, 2)); // buf1 dropped

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.en, v.fs, v.req, v.done, v.rdy, v.rdone);
      tag = $sformatf("vec%0d", i);
      check({tag, " wr_grant"},     32'(bus.wr_grant),     32'(v.grant));
      check({tag, " wr_buf_idx"},   32'(bus.wr_buf_idx),   32'(v.widx));
      check({tag, " rd_cmd_valid"}, 32'(bus.rd_cmd_valid), 32'(v.valid));
      check({tag, " rd_cmd_addr"},  bus.rd_cmd_addr,       v.addr);
      check({tag, " rd_cmd_len"},   32'(bus.rd_cmd_len),   32'(FRAME_BYTES));
      check({tag, " rd_buf_idx"},   32'(bus.rd_buf_idx),   32'(v.ridx));
      check({tag, " sched_state"},  32'(bus.sched_state),  32'(v.st));
      check({tag, " drop_cnt"},     32'(bus.drop_cnt),     exp_cnt(v.drop));
      check({tag, " repeat_cnt"},   32'(bus.repeat_cnt),   exp_cnt(v.rep));
      check({tag, " underrun_cnt"}, 32'(bus.underrun_cnt), exp_cnt(v.und));
    end

    // --- command held for 10 cycles without ready: everything stays put ---
    do_reset();
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    check_model("stall_start");
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 0, 0, 0, 0);
      tag = $sformatf("stall%0d", c);
      check({tag, " valid"}, 32'(bus.rd_cmd_valid), 32'h1);
      check({tag, " addr"},  bus.rd_cmd_addr,       ADDR_B0);
      check({tag, " len"},   32'(bus.rd_cmd_len),   32'(FRAME_BYTES));
    end
    drive(1, 0, 0, 0, 1, 0);
    check_model("stall_accept");
    check("stall_accept state", 32'(bus.sched_state), 32'h2);

    // --- enable dropped mid-command: sequence completes, no new command ---
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    check_model("en_cmd");
    drive(0, 0, 0, 0, 1, 0);
    check_model("en_busy");
    drive(0, 0, 0, 0, 0, 1);
    check_model("en_idle");
    drive(0, 1, 0, 0, 0, 0);
    check_model("en_off_fs");
    check("en_off_fs state", 32'(bus.sched_state), 32'h0);
    check("en_off_fs valid", 32'(bus.rd_cmd_valid), 32'h0);

    // --- asynchronous reset while BUSY ---
    do_reset();
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    check_model("pre_rst");
    check("pre_rst state", 32'(bus.sched_state), 32'h2);
    #2 rstn = 1'b0;
    #1;
    check("async_rst wr_grant",     32'(bus.wr_grant),     32'h0);
    check("async_rst wr_buf_idx",   32'(bus.wr_buf_idx),   32'h0);
    check("async_rst rd_cmd_valid", 32'(bus.rd_cmd_valid), 32'h0);
    check("async_rst rd_cmd_addr",  bus.rd_cmd_addr,       32'h0);
    check("async_rst rd_buf_idx",   32'(bus.rd_buf_idx),   32'h0);
    check("async_rst sched_state",  32'(bus.sched_state),  32'h0);
    check("async_rst rd_cmd_len",   32'(bus.rd_cmd_len),   32'(FRAME_BYTES));
    model_reset();
    @(negedge sys_clk);
    rstn = 1'b1;
    drive(1, 1, 0, 0, 0, 0);
    check_model("post_rst_fs");

    // --- randomized traffic against the reference model ---
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 15) != 0,
            $urandom_range(0, 7)  == 0,
            $urandom_range(0, 3)  != 0,
            $urandom_range(0, 5)  == 0,
            $urandom_range(0, 1)  == 0,
            $urandom_range(0, 3)  == 0);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_frame_buf_sched.md
# display_frame_buf_sched

Triple/quad frame-buffer scheduler for the HDMI display path. It hands frame buffers in DDR to the frame writer, tracks each buffer's state, and issues one read command per display frame to the display DMA channel. The display DMA channel feeds the YUV display pipeline. The block sits in the `sys_clk` domain, between the writer DMA, the display DMA command port and the display frame-start strobe.

## Interface
Parameters:
- `NUM_BUF`, 3 — buffer count; legal values are 3 and 4.
- `ADDR_WIDTH`, 32 — DMA address width.
- `BASE_ADDR`, 32'h0100_0000 — start address of buffer 0.
- `FRAME_BYTES`, 24'd1843200 — bytes per frame (1280x720 at 16 bpp); buffer k address = `BASE_ADDR + k*FRAME_BYTES`, computed at elaboration, modulo 2^ADDR_WIDTH.

Ports:
- `sys_clk` in 1 — the only clock.
- `rstn` in 1 — asynchronous, active-low reset.
- `enable` in 1 — level; enables read command issue.
- `frame_start` in 1 — one-cycle pulse, display VS already synchronised to `sys_clk`.
- `wr_req` in 1 — level; writer requests a buffer and holds the request until `wr_grant`.
- `wr_grant` out 1 — one-cycle grant pulse.
- `wr_buf_idx` out 2 — granted buffer index; valid from `wr_grant` until the next grant.
- `wr_done` in 1 — one-cycle pulse; the granted buffer is fully written.
- `rd_cmd_valid` out 1 — read command valid.
- `rd_cmd_ready` in 1 — read command accepted.
- `rd_cmd_addr` out ADDR_WIDTH — start address of the buffer to read.
- `rd_cmd_len` out 24 — equals `FRAME_BYTES`.
- `rd_done` in 1 — one-cycle pulse; the DMA finished reading the frame.
- `rd_buf_idx` out 2 — index of the buffer currently READING.
- `sched_state` out 2 — 0 IDLE, 1 CMD, 2 BUSY.
- `underrun_cnt`, `repeat_cnt`, `drop_cnt` out 16 each — saturating statistics counters.

## Operation
- Each buffer holds a 2-bit state: FREE, WRITING, READY or READING.
- At most one buffer is WRITING, at most one is READY and at most one is READING.
- **Write side**
  - `wr_grant` is asserted when `wr_req`=1, no buffer is WRITING and at least one buffer is FREE.
  - The lowest-index FREE buffer is chosen; it becomes WRITING and its index drives `wr_buf_idx`.
  - On `wr_done`, the WRITING buffer becomes READY. Any previously READY buffer becomes FREE and `drop_cnt` increments.
  - `wr_done` with no WRITING buffer is ignored.
- **Read FSM**
  - IDLE → CMD on `frame_start` while `enable`=1, provided a READY or READING buffer exists.
  - Buffer selection on entering CMD:
    - If a READY buffer exists, it becomes READING and the old READING buffer becomes FREE.
    - Otherwise the current READING buffer is reused and `repeat_cnt` increments.
  - If neither a READY nor a READING buffer exists, the FSM stays in IDLE and issues no command.
  - CMD: `rd_cmd_valid`=1. Once asserted, valid stays high and addr/len stay stable until `rd_cmd_ready`=1. Then CMD → BUSY.
  - BUSY → IDLE on `rd_done`.
  - `frame_start` in CMD or BUSY: `underrun_cnt` increments and the pulse is otherwise ignored.
  - `enable` deasserted mid-command: the current CMD/BUSY sequence completes; no new command is issued afterwards.
  - `rd_done` outside BUSY is ignored.
- **Simultaneous events**
  - `wr_done` and `frame_start` in the same cycle: the newly READY buffer is eligible for selection in that cycle.
  - `wr_done` and `wr_req` in the same cycle: a grant can issue no earlier than the next cycle.
- Counters saturate at 16'hFFFF.
- Reset mid-operation: all buffers return to FREE, the FSM returns to IDLE, and all outputs take their reset values. The DMA side is responsible for flushing its own state.

## Timing
- Reset values:
  - `wr_grant`=0, `wr_buf_idx`=0, `rd_cmd_valid`=0, `rd_cmd_addr`=0, `rd_buf_idx`=0.
  - `sched_state`=IDLE, all counters 0.
  - `rd_cmd_len` is constant at `FRAME_BYTES`.
- All outputs are registered.
- `frame_start` at cycle N gives `rd_cmd_valid`=1 and updated `rd_cmd_addr`/`rd_buf_idx` at N+1.
- A handshake at cycle M gives `rd_cmd_valid`=0 and `sched_state`=BUSY at M+1.
- `wr_req` high at cycle N with a buffer available gives `wr_grant`=1 at N+1. `wr_grant` is never high for two consecutive cycles.
- `rd_done` at cycle N gives IDLE at N+1. A `frame_start` at N+1 is then accepted.

## Configuration
- `DISPLAY_FRAME_BUF_SCHED_STATS_EN` defined: `underrun_cnt`, `repeat_cnt` and `drop_cnt` are implemented as specified.
- Macro undefined: the three counters are tied to 16'h0 and no counter logic is synthesised. Scheduling behaviour is identical in both cases.

## Test plan
- Reset, then `wr_req`=1: `wr_grant` pulses with `wr_buf_idx`=0. After `wr_done`, `frame_start` → `rd_cmd_valid`, `rd_cmd_addr`=32'h0100_0000, `rd_buf_idx`=0.
- Writer completes buffers 1 and 2 without any reader activity: buffer 1 is dropped (`drop_cnt`=1). The next `frame_start` reads buffer 2 at address 32'h0100_0000+2*1843200 = 32'h0138_4000.
- `frame_start` with no new READY buffer: buffer 0 is re-read and `repeat_cnt`=1. `frame_start` with no buffer ever written: no command is issued and all counters stay 0.
- Hold `rd_cmd_ready`=0 for 10 cycles: valid, addr and len stay stable. Two `frame_start` pulses during CMD/BUSY → `underrun_cnt`=2.
- Same-cycle `wr_done` and `frame_start`: the just-written buffer is selected.
- `rstn` pulled low during BUSY: all outputs return to reset values asynchronously.
- Rebuild without the macro: counters read 0.
